fifo_stream_rd: RTL

Read-side adapter directly downstream of the width-converting synchronous FIFO. Issues pops on the FIFO's `rd_ea`/`empty` interface, absorbs the FIFO's fixed read latency, and presents the narrow words as a valid/ready stream with full throughput and no word loss under back-pressure. Instantiated once per FIFO, clocked with it; the stream side feeds the consumer datapath.

---
 rtl/fifo_stream_rd.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_stream_rd.sv
// fifo_stream_rd: read-side adapter for the width-converting synchronous FIFO.
// Issues pops on the FIFO rd_ea/empty interface, tracks words in flight through
// the FIFO's fixed read latency, and parks them in a small skid buffer that is
// presented downstream as a valid/ready stream.
// Optional build macro FIFO_STREAM_RD_STATS_EN adds the stall_cnt port, a
// saturating count of cycles in which a word waited on the consumer.
module fifo_stream_rd #(
  parameter int WIDTH      = 1,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             fifo_empty,
  output logic             fifo_rd_ea,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_STREAM_RD_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // One entry per word that can be outstanding when pops stop: the in-flight
  // words plus the one currently being offered downstream.
  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W     = CNT_W + 1;

  logic [RD_LATENCY-1:0] vld_p;
  logic [WIDTH-1:0]      mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [OCC_W-1:0]      inflight;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      limit;
  logic                  capture;
  logic                  hs;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign capture = vld_p[RD_LATENCY-1];
  assign m_valid = (count != '0);
  assign hs      = m_valid && m_ready;
  // Empty buffer presents zero so the reset value of m_data needs no data reset.
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // Count pops that have been issued but whose data has not yet been captured
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + OCC_W'(vld_p[i]);
  end

  // Pop only when the word is guaranteed a slot; a handshake this cycle frees one.
  // Comparing against BUF_DEPTH+hs avoids an unsigned underflow on occ-hs.
  always_comb begin
    occ        = OCC_W'(count) + inflight;
    limit      = OCC_W'(BUF_DEPTH) + OCC_W'(hs);
    fifo_rd_ea = !fifo_empty && !flush && !rst && (occ < limit);
  end

  // ---- stage: pop issued -> FIFO read latency (in-flight valid shift) ----
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= fifo_rd_ea;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // ---- stage: capture into skid buffer / hand off to consumer ----
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (capture) wr_ptr <= next_ptr(wr_ptr);
      if (hs)      rd_ptr <= next_ptr(rd_ptr);
      case ({capture, hs})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Skid buffer storage: data only, never reset (count/pointers qualify it)
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= fifo_dout;
  end

`ifdef FIFO_STREAM_RD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  // Stall statistics survive flush; only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
